morra_match_ctrl: RTL and testbench
===================================

// Module: morra_match_ctrl
// PURPOSE
// Match sequencer in front of the MorraCinese game engine. Runs a valid/ready handshake with each player
// and collects one move per player. Configures the engine at match start, presents each move pair for one
// cycle, and captures the engine's MANCHE/PARTITA result. Keeps the engine's move inputs at nomove (00)
// between rounds, so the engine never advances on stale data.
// PARAMETERS
// CFG_CYCLES  2   cycles G_INIZIA is held high in CONFIG (min 1)
// TIMEOUT     16  COLLECT cycle limit before missing moves become nomove (only with MORRA_TIMEOUT_EN)
// PORTS
// clk          in   1  clock; all state updates on rising edge
// INIZIA       in   1  asynchronous, active-high reset of this controller
// START        in   1  one-cycle request: start/restart a match
// CFG          in   4  extra manches; engine max = CFG+4; sampled when START=1
// P1_MOSSA     in   2  player-1 move (00 nomove,01 sasso,10 carta,11 forbice)
// P1_VALID     in   1  P1_MOSSA valid
// P1_READY     out  1  controller accepts P1 move
// P2_MOSSA/P2_VALID/P2_READY  same as P1, player 2
// G_PRIMO      out  2  to engine PRIMO
// G_SECONDO    out  2  to engine SECONDO
// G_INIZIA     out  1  to engine INIZIA
// G_MANCHE     in   2  from engine MANCHE
// G_PARTITA    in   2  from engine PARTITA
// RIS_MANCHE   out  2  last manche result, valid with RIS_VALID
// RIS_VALID    out  1  one-cycle pulse per issued move pair
// RIS_PARTITA  out  2  final match result; held until next START
// ROUNDS       out  5  count of non-invalid manches this match; saturates at 31
// BUSY         out  1  high in CONFIG/COLLECT/ISSUE/CHECK
// DONE         out  1  high in DONE
// BEHAVIOUR
// - Reset (INIZIA=1, async): state=IDLE; all outputs 0; slots empty; CFG register 0.
// - States: IDLE, CONFIG, COLLECT, ISSUE, CHECK, DONE.
// - START=1 in any state except CONFIG -> next state CONFIG; CFG latched; slots and ROUNDS cleared.
//   RIS_PARTITA=0, DONE=0. START has priority over every other transition.
// - CONFIG: G_INIZIA=1, G_PRIMO=CFG[3:2], G_SECONDO=CFG[1:0] for exactly CFG_CYCLES cycles, then COLLECT.
// - Outside CONFIG: G_INIZIA=0. Outside ISSUE: G_PRIMO=G_SECONDO=00.
// - COLLECT: Pn_READY=1 while slot n empty and START=0. Transfer on VALID&&READY; slot n = Pn_MOSSA.
//   Moves of 00 are accepted unchanged. Both slots full at a rising edge -> ISSUE.
//   Both players may transfer in the same cycle; the next cycle is then ISSUE.
// - ISSUE (1 cycle): G_PRIMO=slot1, G_SECONDO=slot2; the engine samples on the closing edge. READY=0.
// - CHECK (1 cycle): G moves=00. On the closing edge: register RIS_MANCHE<=G_MANCHE, pulse RIS_VALID=1
//   for the next cycle, and increment ROUNDS if G_MANCHE!=00 and ROUNDS<31. Clear both slots.
//   G_PARTITA!=00 -> DONE with RIS_PARTITA<=G_PARTITA; otherwise -> COLLECT.
// - Latency: both slots full -> result registered 2 edges later (ISSUE, CHECK); RIS_VALID 1 cycle after CHECK.
// - DONE: READY=0, G outputs idle; stays until START or reset. IDLE behaves the same, with DONE=0.
// - Async reset mid-match: immediate return to IDLE; G_INIZIA drops to 0; the engine is re-configured only via START.
// CONFIGURATION
// MORRA_TIMEOUT_EN defined: a cycle counter, width $clog2(TIMEOUT+1), clears on entry to COLLECT and
//   increments each COLLECT cycle. If the counter reaches TIMEOUT-1 with a slot still empty, every empty
//   slot is filled with 00 and the next state is ISSUE. The engine returns invalid; ROUNDS is unchanged.
//   A transfer on the timeout edge is honoured.
// MORRA_TIMEOUT_EN undefined: no counter; COLLECT waits indefinitely; TIMEOUT is unused.
// TESTING
// 1 Reset: INIZIA=1 mid-COLLECT -> same cycle all outputs 0, BUSY=0. Release, no START -> remains IDLE.
// 2 START, CFG=4'b0110 -> G_INIZIA=1 for 2 cycles with G_PRIMO=01, G_SECONDO=10; then COLLECT, P1_READY=P2_READY=1.
// 3 P1 01 at cycle n, P2 11 at n+3 -> ISSUE at n+4 driving 01/11; RIS_VALID pulse, RIS_MANCHE=01, ROUNDS=1.
// 4 Rounds (01,11),(10,01),(11,11),(01,01) -> RIS_MANCHE 01,01,11,11; DONE=1, RIS_PARTITA=01, ROUNDS=4.
// 5 MORRA_TIMEOUT_EN, TIMEOUT=16; only P1 submits 10 -> after 16 COLLECT cycles ISSUE drives 10/00;
//   RIS_MANCHE=00, ROUNDS unchanged, back to COLLECT with both READY=1.
// 6 START and P1_VALID in the same COLLECT cycle -> P1_READY=0, no transfer, CONFIG next; START in DONE -> CONFIG.

Source files
------------

// File: rtl/morra_match_ctrl.sv
// morra_match_ctrl: sequences a MorraCinese match, collecting one move per player and feeding the engine.
// Latency: last move accepted -> ISSUE next cycle -> CHECK -> RIS_VALID pulse one cycle after CHECK.
// Backpressure: Pn_READY only while slot n is empty in COLLECT and START is low; MORRA_TIMEOUT_EN adds a COLLECT watchdog.
module morra_match_ctrl #(
    parameter int CFG_CYCLES = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       INIZIA,
    input  logic       START,
    input  logic [3:0] CFG,
    input  logic [1:0] P1_MOSSA,
    input  logic       P1_VALID,
    output logic       P1_READY,
    input  logic [1:0] P2_MOSSA,
    input  logic       P2_VALID,
    output logic       P2_READY,
    output logic [1:0] G_PRIMO,
    output logic [1:0] G_SECONDO,
    output logic       G_INIZIA,
    input  logic [1:0] G_MANCHE,
    input  logic [1:0] G_PARTITA,
    output logic [1:0] RIS_MANCHE,
    output logic       RIS_VALID,
    output logic [1:0] RIS_PARTITA,
    output logic [4:0] ROUNDS,
    output logic       BUSY,
    output logic       DONE
);

    localparam int CW = (CFG_CYCLES > 1) ? $clog2(CFG_CYCLES) : 1;
    localparam logic [CW-1:0] CFG_LAST = CW'(CFG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_COLLECT,
        S_ISSUE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cfg_cnt;
    logic [3:0]    cfg_q;
    logic [1:0]    slot1;
    logic [1:0]    slot2;
    logic          full1;
    logic          full2;
    logic          fire1;
    logic          fire2;
    logic          start_acc;
    logic          timeout_hit;
    logic [1:0]    ris_manche_q;
    logic [1:0]    ris_partita_q;
    logic          ris_valid_q;
    logic [4:0]    rounds_q;

    // START restarts the match from anywhere except while the engine is being configured
    assign start_acc = START && (state != S_CONFIG);

`ifdef MORRA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;

    assign timeout_hit = (state == S_COLLECT) && (tcnt == TW'(TIMEOUT - 1));

    // COLLECT cycle counter; held at zero outside COLLECT so every entry starts fresh
    always_ff @(posedge clk or posedge INIZIA) begin
        if (INIZIA) begin
            tcnt <= '0;
        end else if (state != S_COLLECT) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end
`else
    // no watchdog: TIMEOUT is non-negative, so this is constant false
    assign timeout_hit = (TIMEOUT < 0);
`endif

    // state register plus CONFIG hold counter
    always_ff @(posedge clk or posedge INIZIA) begin
        if (INIZIA) begin
            state   <= S_IDLE;
            cfg_cnt <= '0;
        end else begin
            state   <= state_nx;
            cfg_cnt <= (state == S_CONFIG) ? cfg_cnt + CW'(1) : '0;
        end
    end

    // next-state and engine/player-facing outputs
    always_comb begin
        state_nx  = state;
        G_INIZIA  = 1'b0;
        G_PRIMO   = 2'b00;
        G_SECONDO = 2'b00;
        P1_READY  = 1'b0;
        P2_READY  = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        fire1     = 1'b0;
        fire2     = 1'b0;
        case (state)
            S_IDLE: begin
            end
            S_CONFIG: begin
                BUSY      = 1'b1;
                G_INIZIA  = 1'b1;
                G_PRIMO   = cfg_q[3:2];
                G_SECONDO = cfg_q[1:0];
                if (cfg_cnt == CFG_LAST) state_nx = S_COLLECT;
            end
            S_COLLECT: begin
                BUSY     = 1'b1;
                P1_READY = !full1 && !START;
                P2_READY = !full2 && !START;
                fire1    = P1_VALID && P1_READY;
                fire2    = P2_VALID && P2_READY;
                // empty slots already hold 00, so a watchdog expiry issues nomove for them
                if (((full1 || fire1) && (full2 || fire2)) || timeout_hit) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                BUSY      = 1'b1;
                G_PRIMO   = slot1;
                G_SECONDO = slot2;
                state_nx  = S_CHECK;
            end
            S_CHECK: begin
                BUSY     = 1'b1;
                state_nx = (G_PARTITA != 2'b00) ? S_DONE : S_COLLECT;
            end
            S_DONE: begin
                DONE = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
        if (start_acc) state_nx = S_CONFIG;
    end

    // latched match configuration and the two move slots
    always_ff @(posedge clk or posedge INIZIA) begin
        if (INIZIA) begin
            cfg_q <= 4'b0000;
            slot1 <= 2'b00;
            slot2 <= 2'b00;
            full1 <= 1'b0;
            full2 <= 1'b0;
        end else if (start_acc) begin
            cfg_q <= CFG;
            slot1 <= 2'b00;
            slot2 <= 2'b00;
            full1 <= 1'b0;
            full2 <= 1'b0;
        end else if (state == S_CHECK) begin
            slot1 <= 2'b00;
            slot2 <= 2'b00;
            full1 <= 1'b0;
            full2 <= 1'b0;
        end else begin
            if (fire1) begin
                slot1 <= P1_MOSSA;
                full1 <= 1'b1;
            end
            if (fire2) begin
                slot2 <= P2_MOSSA;
                full2 <= 1'b1;
            end
        end
    end

    // engine result capture, round counting and the one-cycle result pulse
    always_ff @(posedge clk or posedge INIZIA) begin
        if (INIZIA) begin
            ris_manche_q  <= 2'b00;
            ris_partita_q <= 2'b00;
            ris_valid_q   <= 1'b0;
            rounds_q      <= 5'd0;
        end else if (start_acc) begin
            ris_partita_q <= 2'b00;
            ris_valid_q   <= 1'b0;
            rounds_q      <= 5'd0;
        end else begin
            ris_valid_q <= (state == S_CHECK);
            if (state == S_CHECK) begin
                ris_manche_q <= G_MANCHE;
                if (G_MANCHE != 2'b00 && rounds_q != 5'd31) rounds_q <= rounds_q + 5'd1;
                if (G_PARTITA != 2'b00) ris_partita_q <= G_PARTITA;
            end
        end
    end

    assign RIS_MANCHE  = ris_manche_q;
    assign RIS_PARTITA = ris_partita_q;
    assign RIS_VALID   = ris_valid_q;
    assign ROUNDS      = rounds_q;

endmodule

// File: tb/tb_morra_match_ctrl.sv
// tb_morra_match_ctrl: drives two randomized players against morra_match_ctrl with a simple engine model.
// Latency: checks each cycle of CONFIG/COLLECT/ISSUE/CHECK and the result cycle that follows.
// Backpressure: players hold VALID until READY; random delays and garbage data while VALID is low.
module tb_morra_match_ctrl;

    logic       clk = 1'b0;
    logic       INIZIA, START;
    logic [3:0] CFG;
    logic [1:0] P1_MOSSA, P2_MOSSA;
    logic       P1_VALID, P2_VALID;
    logic       P1_READY, P2_READY;
    logic [1:0] G_PRIMO, G_SECONDO;
    logic       G_INIZIA;
    logic [1:0] G_MANCHE, G_PARTITA;
    logic [1:0] RIS_MANCHE, RIS_PARTITA;
    logic       RIS_VALID;
    logic [4:0] ROUNDS;
    logic       BUSY, DONE;

    int n_checks = 0;
    int n_pass   = 0;

    // reference match state
    int         exp_max, exp_played, exp_w1, exp_w2, exp_rounds;
    logic [1:0] exp_partita;

    always #5 clk = ~clk;

    morra_match_ctrl dut (
        .clk(clk), .INIZIA(INIZIA), .START(START), .CFG(CFG),
        .P1_MOSSA(P1_MOSSA), .P1_VALID(P1_VALID), .P1_READY(P1_READY),
        .P2_MOSSA(P2_MOSSA), .P2_VALID(P2_VALID), .P2_READY(P2_READY),
        .G_PRIMO(G_PRIMO), .G_SECONDO(G_SECONDO), .G_INIZIA(G_INIZIA),
        .G_MANCHE(G_MANCHE), .G_PARTITA(G_PARTITA),
        .RIS_MANCHE(RIS_MANCHE), .RIS_VALID(RIS_VALID), .RIS_PARTITA(RIS_PARTITA),
        .ROUNDS(ROUNDS), .BUSY(BUSY), .DONE(DONE)
    );

    // game rule: 01 sasso beats 11 forbice, 11 beats 10 carta, 10 beats 01; any nomove is invalid
    function automatic logic [1:0] manche_of(input logic [1:0] a, input logic [1:0] b);
        if (a == 2'b00 || b == 2'b00) return 2'b00;
        if (a == b) return 2'b11;
        if ((a == 2'b01 && b == 2'b11) || (a == 2'b10 && b == 2'b01) || (a == 2'b11 && b == 2'b10)) return 2'b01;
        return 2'b10;
    endfunction

    // engine stand-in: configured while G_INIZIA, plays on nonzero moves, match ends after CFG+4 valid manches
    logic [4:0] e_max, e_played, e_w1, e_w2, e_np, e_nw1, e_nw2;
    logic [1:0] e_m;
    assign e_m   = manche_of(G_PRIMO, G_SECONDO);
    assign e_np  = e_played + 5'((e_m != 2'b00) ? 1 : 0);
    assign e_nw1 = e_w1 + 5'((e_m == 2'b01) ? 1 : 0);
    assign e_nw2 = e_w2 + 5'((e_m == 2'b10) ? 1 : 0);

    always @(posedge clk or posedge INIZIA) begin
        if (INIZIA) begin
            e_max <= 5'd4; e_played <= 5'd0; e_w1 <= 5'd0; e_w2 <= 5'd0;
            G_MANCHE <= 2'b00; G_PARTITA <= 2'b00;
        end else if (G_INIZIA) begin
            e_max <= 5'({G_PRIMO, G_SECONDO}) + 5'd4;
            e_played <= 5'd0; e_w1 <= 5'd0; e_w2 <= 5'd0;
            G_MANCHE <= 2'b00; G_PARTITA <= 2'b00;
        end else if (G_PRIMO == 2'b00 && G_SECONDO == 2'b00) begin
            G_MANCHE <= 2'b00;
        end else begin
            G_MANCHE <= e_m;
            e_played <= e_np; e_w1 <= e_nw1; e_w2 <= e_nw2;
            if (e_m != 2'b00 && e_np == e_max)
                G_PARTITA <= (e_nw1 > e_nw2) ? 2'b01 : (e_nw2 > e_nw1) ? 2'b10 : 2'b11;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        INIZIA = 1'b0; START = 1'b0; CFG = 4'b0000;
        P1_MOSSA = 2'b00; P2_MOSSA = 2'b00; P1_VALID = 1'b0; P2_VALID = 1'b0;
        #1 INIZIA = 1'b1;
        #1;
        n_checks++;
        if ({P1_READY, P2_READY, G_INIZIA, G_PRIMO, G_SECONDO, RIS_MANCHE, RIS_VALID, RIS_PARTITA, ROUNDS, BUSY, DONE} !== 19'd0)
            $display("FAIL reset_outputs got=%b want=0", {P1_READY, P2_READY, G_INIZIA, G_PRIMO, G_SECONDO, RIS_MANCHE, RIS_VALID, RIS_PARTITA, ROUNDS, BUSY, DONE});
        else n_pass++;
        step(); step();
        INIZIA = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({BUSY, DONE, P1_READY, P2_READY, G_INIZIA} !== 5'b0)
                $display("FAIL idle_hold got=%b want=00000", {BUSY, DONE, P1_READY, P2_READY, G_INIZIA});
            else n_pass++;
        end
    endtask

    task automatic start_match(input logic [3:0] cfg);
        START = 1'b1; CFG = cfg;
        #1;
        n_checks++;
        if ({P1_READY, P2_READY} !== 2'b00) $display("FAIL start_blocks_ready got=%b want=00", {P1_READY, P2_READY});
        else n_pass++;
        step();
        START = 1'b0; CFG = 4'($urandom); P1_VALID = 1'b0; P2_VALID = 1'b0;
        exp_max = int'(cfg) + 4; exp_played = 0; exp_w1 = 0; exp_w2 = 0; exp_rounds = 0; exp_partita = 2'b00;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if ({G_INIZIA, G_PRIMO, G_SECONDO, BUSY, DONE, RIS_PARTITA, ROUNDS} !== {1'b1, cfg, 1'b1, 1'b0, 2'b00, 5'd0})
                $display("FAIL config_cycle%0d got=%b want=%b", i, {G_INIZIA, G_PRIMO, G_SECONDO, BUSY, DONE, RIS_PARTITA, ROUNDS}, {1'b1, cfg, 1'b1, 1'b0, 2'b00, 5'd0});
            else n_pass++;
            step();
        end
        #1;
        n_checks++;
        if ({G_INIZIA, G_PRIMO, G_SECONDO, P1_READY, P2_READY, BUSY} !== 8'b0_00_00_111)
            $display("FAIL collect_entry got=%b want=00000111", {G_INIZIA, G_PRIMO, G_SECONDO, P1_READY, P2_READY, BUSY});
        else n_pass++;
    endtask

    // one round from COLLECT: each player raises VALID after its delay and holds it until READY
    task automatic play_round(input logic [1:0] m1, input int d1, input logic [1:0] m2, input int d2);
        bit s1 = 0, s2 = 0, f1, f2;
        int c = 0;
        logic [1:0] em;
        logic ed;
        while (!(s1 && s2) && c < 40) begin
            P1_VALID = !s1 && c >= d1; P1_MOSSA = P1_VALID ? m1 : 2'($urandom);
            P2_VALID = !s2 && c >= d2; P2_MOSSA = P2_VALID ? m2 : 2'($urandom);
            #1;
            n_checks++;
            if ({P1_READY, P2_READY, G_PRIMO, G_SECONDO} !== {!s1, !s2, 4'b0000})
                $display("FAIL collect_ready c=%0d got=%b want=%b", c, {P1_READY, P2_READY, G_PRIMO, G_SECONDO}, {!s1, !s2, 4'b0000});
            else n_pass++;
            f1 = P1_VALID && P1_READY; f2 = P2_VALID && P2_READY;
            step();
            s1 = s1 || f1; s2 = s2 || f2;
            c++;
        end
        P1_VALID = 1'b0; P2_VALID = 1'b0;
        if (!(s1 && s2)) begin
            n_checks++;
            $display("FAIL handshake_timeout got=%b%b want=11", s1, s2);
            return;
        end
        #1;
        n_checks++;
        if ({G_PRIMO, G_SECONDO, G_INIZIA, P1_READY, P2_READY, BUSY, RIS_VALID} !== {m1, m2, 5'b00010})
            $display("FAIL issue got=%b want=%b", {G_PRIMO, G_SECONDO, G_INIZIA, P1_READY, P2_READY, BUSY, RIS_VALID}, {m1, m2, 5'b00010});
        else n_pass++;
        step();
        n_checks++;
        if ({G_PRIMO, G_SECONDO, P1_READY, P2_READY, BUSY, RIS_VALID} !== 8'b0000_0010)
            $display("FAIL check_cycle got=%b want=00000010", {G_PRIMO, G_SECONDO, P1_READY, P2_READY, BUSY, RIS_VALID});
        else n_pass++;
        em = manche_of(m1, m2);
        if (em != 2'b00) begin
            exp_played++;
            if (exp_rounds < 31) exp_rounds++;
            if (em == 2'b01) exp_w1++;
            if (em == 2'b10) exp_w2++;
            if (exp_played == exp_max)
                exp_partita = (exp_w1 > exp_w2) ? 2'b01 : (exp_w2 > exp_w1) ? 2'b10 : 2'b11;
        end
        ed = (exp_partita != 2'b00);
        step();
        n_checks++;
        if ({RIS_VALID, RIS_MANCHE, ROUNDS, DONE, BUSY, RIS_PARTITA, P1_READY, P2_READY} !== {1'b1, em, 5'(exp_rounds), ed, !ed, exp_partita, !ed, !ed})
            $display("FAIL result m=%b/%b got=%b want=%b", m1, m2, {RIS_VALID, RIS_MANCHE, ROUNDS, DONE, BUSY, RIS_PARTITA, P1_READY, P2_READY}, {1'b1, em, 5'(exp_rounds), ed, !ed, exp_partita, !ed, !ed});
        else n_pass++;
    endtask

    task automatic test_config();
        start_match(4'b0110);
    endtask

    task automatic test_first_round();
        play_round(2'b01, 0, 2'b11, 3);
    endtask

    task automatic test_reset_mid();
        P1_VALID = 1'b1; P1_MOSSA = 2'b10;
        step();
        P1_VALID = 1'b0;
        #1 INIZIA = 1'b1;
        #1;
        n_checks++;
        if ({P1_READY, P2_READY, G_INIZIA, G_PRIMO, G_SECONDO, RIS_MANCHE, RIS_VALID, RIS_PARTITA, ROUNDS, BUSY, DONE} !== 19'd0)
            $display("FAIL reset_mid got=%b want=0", {P1_READY, P2_READY, G_INIZIA, G_PRIMO, G_SECONDO, RIS_MANCHE, RIS_VALID, RIS_PARTITA, ROUNDS, BUSY, DONE});
        else n_pass++;
        step();
        INIZIA = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({BUSY, DONE, P1_READY, P2_READY, G_INIZIA, ROUNDS} !== 10'd0)
                $display("FAIL reset_idle got=%b want=0", {BUSY, DONE, P1_READY, P2_READY, G_INIZIA, ROUNDS});
            else n_pass++;
        end
    endtask

    task automatic test_full_match();
        start_match(4'b0000);
        play_round(2'b01, 0, 2'b11, 3);
        play_round(2'b10, 1, 2'b01, 0);
        play_round(2'b11, 0, 2'b11, 0);
        play_round(2'b01, 2, 2'b01, 2);
        for (int i = 0; i < 3; i++) begin
            P1_VALID = 1'b1; P1_MOSSA = 2'b01;
            step();
            n_checks++;
            if ({DONE, BUSY, RIS_PARTITA, RIS_VALID, P1_READY, P2_READY, G_PRIMO, G_SECONDO, ROUNDS} !== {4'b1001, 3'b000, 4'b0000, 5'd4})
                $display("FAIL done_hold got=%b want=%b", {DONE, BUSY, RIS_PARTITA, RIS_VALID, P1_READY, P2_READY, G_PRIMO, G_SECONDO, ROUNDS}, {4'b1001, 3'b000, 4'b0000, 5'd4});
            else n_pass++;
        end
        P1_VALID = 1'b0;
    endtask

    task automatic test_start_priority();
        start_match(4'b0001);
        P1_VALID = 1'b1; P1_MOSSA = 2'b01;
        start_match(4'b0010);
        play_round(2'b10, 0, 2'b01, 0);
    endtask

    task automatic test_timeout();
        start_match(4'b0000);
`ifdef MORRA_TIMEOUT_EN
        for (int c = 0; c < 16; c++) begin
            P1_VALID = (c == 0); P1_MOSSA = 2'b10;
            #1;
            n_checks++;
            if ({P1_READY, P2_READY, G_PRIMO, G_SECONDO} !== {(c == 0), 1'b1, 4'b0000})
                $display("FAIL timeout_collect c=%0d got=%b want=%b", c, {P1_READY, P2_READY, G_PRIMO, G_SECONDO}, {(c == 0), 1'b1, 4'b0000});
            else n_pass++;
            step();
        end
        P1_VALID = 1'b0;
        #1;
        n_checks++;
        if ({G_PRIMO, G_SECONDO, BUSY} !== 5'b10_00_1) $display("FAIL timeout_issue got=%b want=10001", {G_PRIMO, G_SECONDO, BUSY});
        else n_pass++;
        step(); step();
        n_checks++;
        if ({RIS_VALID, RIS_MANCHE, ROUNDS, P1_READY, P2_READY, DONE} !== {1'b1, 2'b00, 5'd0, 3'b110})
            $display("FAIL timeout_result got=%b want=%b", {RIS_VALID, RIS_MANCHE, ROUNDS, P1_READY, P2_READY, DONE}, {1'b1, 2'b00, 5'd0, 3'b110});
        else n_pass++;
`else
        // without the watchdog COLLECT waits as long as player 2 needs
        play_round(2'b10, 0, 2'b01, 24);
`endif
    endtask

    task automatic test_random();
        logic [1:0] a, b;
        for (int k = 0; k < 5; k++) begin
            start_match(4'($urandom_range(0, 15)));
            for (int r = 0; r < 64 && exp_partita == 2'b00; r++) begin
                a = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                b = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                play_round(a, $urandom_range(0, 4), b, $urandom_range(0, 4));
            end
            n_checks++;
            if (DONE !== 1'b1) $display("FAIL random_match_end k=%0d got=%b want=1", k, DONE);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_first_round();
        test_reset_mid();
        test_full_match();
        test_start_priority();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL sim_time_limit got=expired want=finished");
        $fatal(1, "time limit");
    end

endmodule
